// File: rtl/gcm_pkg.sv
// Shared definitions for the GCM datapath: bus widths and the GCTR sequencer state encoding.
package gcm_pkg;

    localparam int unsigned BLK_W   = 128;
    localparam int unsigned KEY_W   = 256;
    localparam int unsigned IV_W    = 96;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned BYTES_N = BLK_W / 8;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CLR     = 4'd1,
        ST_JOB_H   = 4'd2,
        ST_JOB_Y0  = 4'd3,
        ST_WAIT_IN = 4'd4,
        ST_JOB_D   = 4'd5,
        ST_OUT     = 4'd6,
        ST_GAP     = 4'd7,
        ST_DONE    = 4'd8
    } gctr_state_t;

endpackage

// File: rtl/gcm_byte_mask.sv
// Last-block byte mask: byte j occupies bits [8j:8j+7]; bytes at or beyond len are zeroed.
// A length of 0 denotes a full 16-byte block and passes the data through untouched.
module gcm_byte_mask
    import gcm_pkg::*;
(
    input  logic [0:BLK_W-1] data,
    input  logic [LEN_W-1:0] len,
    output logic [0:BLK_W-1] masked_c
);

    always_comb begin
        masked_c = data;
        for (int unsigned j = 0; j < BYTES_N; j++) begin
            if ((len != '0) && (LEN_W'(j) >= len)) begin
                masked_c[8*j +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/gcm_gctr_sequencer.sv
// Drives gctr_block through one GCM message: hash key job, E(K,Y0) job, then one job per data
// block, with valid/ready streams on the data side and a masked final block.
module gcm_gctr_sequencer
    import gcm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               iClk,
    input  logic               iRstn,
    input  logic               iStart,
    input  logic [0:KEY_W-1]   iKey,
    input  logic               iKeylen,
    input  logic               iEncdec,
    input  logic [0:IV_W-1]    iIV,
    input  logic [CNT_W-1:0]   iNumBlocks,
    input  logic [LEN_W-1:0]   iLastBytes,
    input  logic [0:BLK_W-1]   iData,
    input  logic               iData_valid,
    output logic               oData_ready,
    output logic [0:BLK_W-1]   oData,
    output logic               oData_valid,
    input  logic               iOut_ready,
    output logic [0:BLK_W-1]   oH,
    output logic               oH_valid,
    output logic [0:BLK_W-1]   oEkY0,
    output logic               oEkY0_valid,
    output logic               oBusy,
    output logic               oDone,
    output logic               oGctrRstn,
    output logic               oGctrInit,
    output logic [0:KEY_W-1]   oGctrKey,
    output logic               oGctrKeylen,
    output logic               oGctrEncdec,
    output logic [0:IV_W-1]    oGctrIV,
    output logic               oGctrKey_valid,
    output logic               oGctrIV_valid,
    output logic               oGctrBlock_valid,
    output logic               oGctrHashKey,
    output logic               oGctrY0,
    output logic [0:BLK_W-1]   oGctrBlock,
    input  logic [0:BLK_W-1]   iGctrResult,
    input  logic               iGctrResult_valid
);

    gctr_state_t      state;
    gctr_state_t      gap_next;
    logic [CNT_W-1:0] rem_cnt;
    logic [LEN_W-1:0] last_bytes_q;
    logic             clr_q;
    logic [LEN_W-1:0] mask_len_c;
    logic [0:BLK_W-1] masked_c;

    // Restarts the gctr_block counter for one cycle at the start of every message.
    assign oGctrRstn = iRstn & ~clr_q;

    // Only the final data block of the message is truncated.
    assign mask_len_c = (rem_cnt == CNT_W'(1)) ? last_bytes_q : '0;

    gcm_byte_mask u_mask (
        .data     (iGctrResult),
        .len      (mask_len_c),
        .masked_c (masked_c)
    );

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            state            <= ST_IDLE;
            gap_next         <= ST_IDLE;
            rem_cnt          <= '0;
            last_bytes_q     <= '0;
            clr_q            <= 1'b0;
            oData_ready      <= 1'b0;
            oData            <= '0;
            oData_valid      <= 1'b0;
            oH               <= '0;
            oH_valid         <= 1'b0;
            oEkY0            <= '0;
            oEkY0_valid      <= 1'b0;
            oBusy            <= 1'b0;
            oDone            <= 1'b0;
            oGctrInit        <= 1'b0;
            oGctrKey         <= '0;
            oGctrKeylen      <= 1'b0;
            oGctrEncdec      <= 1'b0;
            oGctrIV          <= '0;
            oGctrKey_valid   <= 1'b0;
            oGctrIV_valid    <= 1'b0;
            oGctrBlock_valid <= 1'b0;
            oGctrHashKey     <= 1'b0;
            oGctrY0          <= 1'b0;
            oGctrBlock       <= '0;
        end else begin
            oDone <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        oGctrKey     <= iKey;
                        oGctrKeylen  <= iKeylen;
                        oGctrEncdec  <= iEncdec;
                        oGctrIV      <= iIV;
                        rem_cnt      <= iNumBlocks;
                        last_bytes_q <= iLastBytes;
                        oH_valid     <= 1'b0;
                        oEkY0_valid  <= 1'b0;
                        oBusy        <= 1'b1;
                        clr_q        <= 1'b1;
                        state        <= ST_CLR;
                    end
                end

                ST_CLR: begin
                    clr_q    <= 1'b0;
                    gap_next <= ST_JOB_H;
                    state    <= ST_GAP;
                end

                // One idle cycle between jobs so gctr_block sees Init low in its IDLE.
                ST_GAP: begin
                    state <= gap_next;
                    if ((gap_next == ST_JOB_H) || (gap_next == ST_JOB_Y0)) begin
                        oGctrInit        <= 1'b1;
                        oGctrKey_valid   <= 1'b1;
                        oGctrIV_valid    <= 1'b1;
                        oGctrBlock_valid <= 1'b1;
                        oGctrHashKey     <= (gap_next == ST_JOB_H);
                        oGctrY0          <= (gap_next == ST_JOB_Y0);
                        oGctrBlock       <= '0;
                    end
                    if (gap_next == ST_WAIT_IN) begin
                        oData_ready <= 1'b1;
                    end
                    if (gap_next == ST_DONE) begin
                        oDone <= 1'b1;
                    end
                end

                ST_JOB_H: begin
                    if (iGctrResult_valid) begin
                        oH               <= iGctrResult;
                        oH_valid         <= 1'b1;
                        oGctrInit        <= 1'b0;
                        oGctrKey_valid   <= 1'b0;
                        oGctrIV_valid    <= 1'b0;
                        oGctrBlock_valid <= 1'b0;
                        oGctrHashKey     <= 1'b0;
                        gap_next         <= ST_JOB_Y0;
                        state            <= ST_GAP;
                    end
                end

                ST_JOB_Y0: begin
                    if (iGctrResult_valid) begin
                        oEkY0            <= iGctrResult;
                        oEkY0_valid      <= 1'b1;
                        oGctrInit        <= 1'b0;
                        oGctrKey_valid   <= 1'b0;
                        oGctrIV_valid    <= 1'b0;
                        oGctrBlock_valid <= 1'b0;
                        oGctrY0          <= 1'b0;
                        gap_next         <= (rem_cnt == '0) ? ST_DONE : ST_WAIT_IN;
                        state            <= ST_GAP;
                    end
                end

                ST_WAIT_IN: begin
                    if (iData_valid) begin
                        oData_ready      <= 1'b0;
                        oGctrBlock       <= iData;
                        oGctrInit        <= 1'b1;
                        oGctrKey_valid   <= 1'b1;
                        oGctrIV_valid    <= 1'b1;
                        oGctrBlock_valid <= 1'b1;
                        oGctrHashKey     <= 1'b0;
                        oGctrY0          <= 1'b0;
                        state            <= ST_JOB_D;
                    end
                end

                ST_JOB_D: begin
                    if (iGctrResult_valid) begin
                        oData            <= masked_c;
                        oData_valid      <= 1'b1;
                        oGctrInit        <= 1'b0;
                        oGctrKey_valid   <= 1'b0;
                        oGctrIV_valid    <= 1'b0;
                        oGctrBlock_valid <= 1'b0;
                        state            <= ST_OUT;
                    end
                end

                // The accept cycle doubles as the inter-job gap.
                ST_OUT: begin
                    if (iOut_ready) begin
                        oData_valid <= 1'b0;
                        if (rem_cnt != '0) begin
                            rem_cnt <= rem_cnt - CNT_W'(1);
                        end
                        if (rem_cnt > CNT_W'(1)) begin
                            oData_ready <= 1'b1;
                            state       <= ST_WAIT_IN;
                        end else begin
                            oDone <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    oBusy <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcm_gctr_sequencer.sv
// Self-checking bench for gcm_gctr_sequencer against a stub gctr_block that returns block ^ A5..A5.
module tb_gcm_gctr_sequencer;
    import gcm_pkg::*;

    localparam int unsigned CNT_W = 16;
    localparam logic [0:BLK_W-1] PAD = {16{8'hA5}};

    logic               iClk, iRstn, iStart, iKeylen, iEncdec;
    logic [0:KEY_W-1]   iKey;
    logic [0:IV_W-1]    iIV;
    logic [CNT_W-1:0]   iNumBlocks;
    logic [LEN_W-1:0]   iLastBytes;
    logic [0:BLK_W-1]   iData;
    logic               iData_valid, oData_ready, oData_valid, iOut_ready;
    logic [0:BLK_W-1]   oData, oH, oEkY0, oGctrBlock, iGctrResult;
    logic               oH_valid, oEkY0_valid, oBusy, oDone, oGctrRstn, oGctrInit;
    logic [0:KEY_W-1]   oGctrKey;
    logic               oGctrKeylen, oGctrEncdec;
    logic [0:IV_W-1]    oGctrIV;
    logic               oGctrKey_valid, oGctrIV_valid, oGctrBlock_valid;
    logic               oGctrHashKey, oGctrY0, iGctrResult_valid;

    gcm_gctr_sequencer #(.CNT_W(CNT_W)) dut (
        .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iKey(iKey), .iKeylen(iKeylen),
        .iEncdec(iEncdec), .iIV(iIV), .iNumBlocks(iNumBlocks), .iLastBytes(iLastBytes),
        .iData(iData), .iData_valid(iData_valid), .oData_ready(oData_ready), .oData(oData),
        .oData_valid(oData_valid), .iOut_ready(iOut_ready), .oH(oH), .oH_valid(oH_valid),
        .oEkY0(oEkY0), .oEkY0_valid(oEkY0_valid), .oBusy(oBusy), .oDone(oDone),
        .oGctrRstn(oGctrRstn), .oGctrInit(oGctrInit), .oGctrKey(oGctrKey),
        .oGctrKeylen(oGctrKeylen), .oGctrEncdec(oGctrEncdec), .oGctrIV(oGctrIV),
        .oGctrKey_valid(oGctrKey_valid), .oGctrIV_valid(oGctrIV_valid),
        .oGctrBlock_valid(oGctrBlock_valid), .oGctrHashKey(oGctrHashKey), .oGctrY0(oGctrY0),
        .oGctrBlock(oGctrBlock), .iGctrResult(iGctrResult), .iGctrResult_valid(iGctrResult_valid)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Stub gctr_block: answers 5 cycles after Init, then waits for Init to drop.
    logic st_busy, st_wait_low;
    int   st_cnt;
    always @(posedge iClk) begin
        if (!oGctrRstn) begin
            st_busy <= 1'b0; st_wait_low <= 1'b0; st_cnt <= 0;
            iGctrResult_valid <= 1'b0; iGctrResult <= '0;
        end else begin
            iGctrResult_valid <= 1'b0;
            if (st_wait_low && !oGctrInit) st_wait_low <= 1'b0;
            if (st_busy) begin
                if (st_cnt == 4) begin
                    st_busy <= 1'b0; st_wait_low <= 1'b1;
                    iGctrResult_valid <= 1'b1; iGctrResult <= oGctrBlock ^ PAD;
                end else begin
                    st_cnt <= st_cnt + 1;
                end
            end else if (!st_wait_low && oGctrInit && oGctrKey_valid && oGctrBlock_valid) begin
                st_busy <= 1'b1; st_cnt <= 0;
            end
        end
    end

    int   init_edges = 0, done_cnt = 0, out_cnt = 0;
    logic init_q = 1'b0;
    always @(posedge iClk) begin
        if (oGctrInit && !init_q) init_edges++;
        init_q <= oGctrInit;
        if (oDone) done_cnt++;
        if (oData_valid && iOut_ready) out_cnt++;
    end

    int n_checks = 0, n_fail = 0;
    logic [0:BLK_W-1] sb[$];

    task automatic check_vec(input string name, input logic [0:BLK_W-1] act, input logic [0:BLK_W-1] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [0:BLK_W-1] rnd_blk();
        logic [0:BLK_W-1] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [0:BLK_W-1] expect_blk(input logic [0:BLK_W-1] d, input bit last,
                                                    input logic [LEN_W-1:0] lb);
        logic [0:BLK_W-1] e;
        e = d ^ PAD;
        if (last && lb != 0)
            for (int j = 0; j < 16; j++) if (j >= int'(lb)) e[8*j +: 8] = 8'h00;
        return e;
    endfunction

    typedef struct {
        int               nblk;
        logic [LEN_W-1:0] lb;
        int               stall;
        bit               poke;
        bit               zero;
    } vec_t;

    vec_t vecs[7];

    task automatic run_msg(input vec_t v, input int id);
        logic [0:KEY_W-1] key;
        int e_init, e_done, e_out, t;
        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
        @(negedge iClk);
        iKey = key; iKeylen = id[0]; iEncdec = id[1];
        iIV = {$urandom, $urandom, $urandom};
        iNumBlocks = CNT_W'(v.nblk); iLastBytes = v.lb; iStart = 1'b1;
        e_init = init_edges; e_done = done_cnt; e_out = out_cnt;
        @(negedge iClk);
        iStart = 1'b0;
        check_bit("clr_gctr_rstn", oGctrRstn, 1'b0);
        check_bit("busy_after_start", oBusy, 1'b1);
        fork
            begin
                for (int b = 0; b < v.nblk; b++) begin
                    logic [0:BLK_W-1] d;
                    int tw;
                    d = v.zero ? '0 : rnd_blk();
                    iData = ~d; iData_valid = 1'b1;
                    tw = 0;
                    while (!oData_ready && tw < 400) begin @(negedge iClk); tw++; end
                    if (!oData_ready) begin
                        check_bit("timeout_data_ready", oData_ready, 1'b1);
                        break;
                    end
                    iData = d;
                    sb.push_back(expect_blk(d, b == v.nblk - 1, v.lb));
                    @(negedge iClk);
                    iData_valid = 1'b0;
                end
                iData_valid = 1'b0;
            end
            begin
                for (int b = 0; b < v.nblk; b++) begin
                    logic [0:BLK_W-1] hold, exp;
                    int tw, ie;
                    iOut_ready = (v.stall == 0);
                    tw = 0;
                    while (!oData_valid && tw < 400) begin @(negedge iClk); tw++; end
                    if (!oData_valid) begin
                        check_bit("timeout_data_valid", oData_valid, 1'b1);
                        break;
                    end
                    if (v.stall > 0) begin
                        iOut_ready = 1'b0;
                        hold = oData; ie = init_edges;
                        repeat (v.stall) @(negedge iClk);
                        check_vec("stall_data_stable", oData, hold);
                        check_bit("stall_valid_held", oData_valid, 1'b1);
                        check_bit("stall_ready_low", oData_ready, 1'b0);
                        check_int("stall_no_init", init_edges, ie);
                        iOut_ready = 1'b1;
                    end
                    if (sb.size() == 0) begin
                        check_int("scoreboard_empty", 0, 1);
                    end else begin
                        exp = sb.pop_front();
                        check_vec("data_out", oData, exp);
                    end
                    @(negedge iClk);
                    iOut_ready = 1'b0;
                end
                iOut_ready = 1'b0;
            end
            begin
                if (v.poke) begin
                    int tw;
                    tw = 0;
                    while (!(oGctrY0 && oGctrInit) && tw < 100) begin @(negedge iClk); tw++; end
                    check_bit("y0_job_seen", oGctrY0 && oGctrInit, 1'b1);
                    iStart = 1'b1; iNumBlocks = CNT_W'(v.nblk + 3); iKey = ~key;
                    @(negedge iClk);
                    iStart = 1'b0; iNumBlocks = CNT_W'(v.nblk); iKey = key;
                    check_bit("poke_h_valid_kept", oH_valid, 1'b1);
                    check_vec("poke_h_kept", oH, PAD);
                end
            end
        join
        t = 0;
        while (oBusy && t < 400) begin @(negedge iClk); t++; end
        check_bit("idle_after_msg", oBusy, 1'b0);
        check_vec("hash_key", oH, PAD);
        check_bit("hash_key_valid", oH_valid, 1'b1);
        check_vec("ek_y0", oEkY0, PAD);
        check_bit("ek_y0_valid", oEkY0_valid, 1'b1);
        check_int("init_edges", init_edges - e_init, v.nblk + 2);
        check_int("done_pulses", done_cnt - e_done, 1);
        check_int("blocks_out", out_cnt - e_out, v.nblk);
        check_int("scoreboard_left", sb.size(), 0);
        check_bit("gctr_key_latched", oGctrKey == key, 1'b1);
        check_bit("gctr_keylen_latched", oGctrKeylen, id[0]);
    endtask

    initial begin
        logic [0:BLK_W-1] e3;
        int t;
        e3 = {24'hA5A5A5, 104'h0};
        vecs[0] = '{3, 4'd0,  0,  1'b0, 1'b1};
        vecs[1] = '{1, 4'd3,  0,  1'b0, 1'b1};
        vecs[2] = '{0, 4'd0,  0,  1'b0, 1'b0};
        vecs[3] = '{2, 4'd5,  20, 1'b0, 1'b0};
        vecs[4] = '{3, 4'd1,  2,  1'b1, 1'b0};
        vecs[5] = '{1, 4'd15, 0,  1'b0, 1'b0};
        vecs[6] = '{4, 4'd8,  1,  1'b0, 1'b0};

        iRstn = 1'b0; iStart = 1'b0; iKey = '0; iKeylen = 1'b0; iEncdec = 1'b0; iIV = '0;
        iNumBlocks = '0; iLastBytes = '0; iData = '0; iData_valid = 1'b0; iOut_ready = 1'b0;
        repeat (3) @(negedge iClk);
        check_bit("rst_busy", oBusy, 1'b0);
        check_bit("rst_gctr_rstn", oGctrRstn, 1'b0);
        check_bit("rst_init", oGctrInit, 1'b0);
        check_bit("rst_data_ready", oData_ready, 1'b0);
        check_bit("rst_data_valid", oData_valid, 1'b0);
        check_bit("rst_h_valid", oH_valid, 1'b0);
        check_bit("rst_done", oDone, 1'b0);
        check_vec("rst_data", oData, '0);
        iRstn = 1'b1;
        @(negedge iClk);
        check_bit("run_gctr_rstn", oGctrRstn, 1'b1);

        for (int i = 0; i < 7; i++) begin
            run_msg(vecs[i], i);
            if (i == 1) check_vec("last_block_3_bytes", oData, e3);
        end

        // Reset asserted while a data job is in flight.
        @(negedge iClk);
        iNumBlocks = CNT_W'(2); iLastBytes = '0; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        iData = rnd_blk(); iData_valid = 1'b1;
        t = 0;
        while (!(oGctrInit && oGctrBlock_valid && !oGctrHashKey && !oGctrY0) && t < 200) begin
            @(negedge iClk); t++;
        end
        check_bit("reached_job_d", oGctrInit && !oGctrHashKey && !oGctrY0, 1'b1);
        iData_valid = 1'b0;
        iRstn = 1'b0;
        @(negedge iClk);
        check_bit("midrst_busy", oBusy, 1'b0);
        check_bit("midrst_init", oGctrInit, 1'b0);
        check_bit("midrst_gctr_rstn", oGctrRstn, 1'b0);
        check_bit("midrst_valids", oGctrKey_valid | oGctrIV_valid | oGctrBlock_valid |
                                   oH_valid | oEkY0_valid | oData_valid, 1'b0);
        iRstn = 1'b1;
        repeat (8) @(negedge iClk);
        check_bit("post_rst_idle", oBusy, 1'b0);
        check_bit("post_rst_no_output", oData_valid, 1'b0);
        run_msg(vecs[6], 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
